// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO, 5..9 data bits, optional even/odd parity
// and one or two stop bits. Each bit lasts OVERSAMPLE clk_en pulses. The frame
// configuration is captured when a word leaves the FIFO, so it cannot change
// in the middle of a frame.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clk_en,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          uart_tx,
    output logic                          uart_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } state_e;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 push, pop;

    // Frame engine state
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 cfg_parity_en_q;
    logic                 cfg_two_stop_q;
    logic                 tick_end;
    logic                 line_d;
    logic                 tx_q;
    logic                 busy_q;

    // s_ready comes from the registered level only; a same-cycle pop does not open a slot.
    assign s_ready    = (level_q != LVL_FULL);
    assign push       = s_valid && s_ready;
    assign pop        = (state_q == ST_IDLE) && (level_q != '0);
    assign fifo_level = level_q;
    assign uart_tx    = tx_q;
    assign uart_busy  = busy_q;

    // Last tick of the current bit; never true while idle.
    assign tick_end = clk_en && (cnt_q == CNT_LAST) && (state_q != ST_IDLE);

    // FIFO level after this cycle's push and pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO data array, written on push.
    // NOTE: the array has no reset; the pointers and level already define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // FIFO pointers and level; power-of-two depth lets the pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and the line level implied by the current state.
    always_comb begin
        state_d = state_q;
        line_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (pop) state_d = ST_START;
            end
            ST_START: begin
                line_d = 1'b0;
                if (tick_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                line_d = shift_q[0];
                if (tick_end && (bit_cnt_q == BIT_LAST)) begin
                    state_d = cfg_parity_en_q ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                line_d = parity_q;
                if (tick_end) state_d = ST_STOP1;
            end
            ST_STOP1: begin
                if (tick_end) state_d = cfg_two_stop_q ? ST_STOP2 : ST_IDLE;
            end
            ST_STOP2: begin
                if (tick_end) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Tick and bit counters, shift register and the per-frame config snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q           <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            parity_q        <= 1'b0;
            cfg_parity_en_q <= 1'b0;
            cfg_two_stop_q  <= 1'b0;
        end else if (pop) begin
            cnt_q           <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= mem_q[rd_ptr_q];
            parity_q        <= (^mem_q[rd_ptr_q]) ^ parity_odd;
            cfg_parity_en_q <= parity_en;
            cfg_two_stop_q  <= two_stop;
        end else begin
            if ((state_q != ST_IDLE) && clk_en) begin
                cnt_q <= tick_end ? '0 : cnt_q + CNT_W'(1);
            end
            if ((state_q == ST_DATA) && tick_end) begin
                bit_cnt_q <= (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
                shift_q   <= shift_q >> 1;
            end
        end
    end

    // Registered line and busy outputs; the line lags the FSM by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            tx_q   <= line_d;
            busy_q <= (state_d != ST_IDLE) || (level_d != '0);
        end
    end

endmodule
